// File: rtl/lrelu_cfg_loader_pkg.sv
// Shared state type, widths and beat-count helpers
// for the LeakyReLU config loader.
package lrelu_cfg_loader_pkg;

  localparam int MEMBERS_DEF = 12;
  localparam int KH_MAX_DEF  = 3;
  localparam int KW_MAX_DEF  = 3;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } lrelu_state_t;

  function automatic int clog2m(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

  function automatic int clip(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  // one beat per group of four lanes, per kernel tap
  function automatic int calc_sel_beats(input int members);
    return (members + 3) / 4;
  endfunction

  function automatic int calc_beats_total(
    input int kw2,
    input int members
  );
    return (kw2 + 1) * (kw2 + 1) * calc_sel_beats(members);
  endfunction

  function automatic int calc_beats_max(
    input int kw_max,
    input int members
  );
    return calc_beats_total((kw_max - 1) / 2, members);
  endfunction

  function automatic int calc_beats_total_max();
    return calc_beats_max(KW_MAX_DEF, MEMBERS_DEF);
  endfunction

  localparam int BITS_KH2   = clog2m((KH_MAX_DEF + 1) / 2);
  localparam int BITS_KW2   = clog2m((KW_MAX_DEF + 1) / 2);
  localparam int BITS_KH    = clog2m(KH_MAX_DEF > KW_MAX_DEF ?
                                     KH_MAX_DEF : KW_MAX_DEF);
  localparam int BITS_CLR_I = clog2m((KW_MAX_DEF + 1) / 2);
  localparam int BITS_W_SEL = 2;

  localparam int BITS_BEATS_TOTAL = clog2m(calc_beats_total_max());
  localparam int BITS_W_ADDR      = BITS_BEATS_TOTAL;

endpackage

// File: rtl/lrelu_beats_counter.sv
// Nested beat counter: lane group inside kernel tap
// inside colour, plus a flat beat index.
module lrelu_beats_counter
  import lrelu_cfg_loader_pkg::*;
#(
  parameter int MEMBERS = 12
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   en,
  input  logic [BITS_KW2-1:0]    kw2,
  output logic [BITS_W_SEL-1:0]  sel,
  output logic [BITS_KH-1:0]     mtb,
  output logic [BITS_CLR_I-1:0]  clr_i,
  output logic [BITS_W_ADDR-1:0] addr,
  output logic                   full
);

  localparam int SEL_N = calc_sel_beats(MEMBERS);

  logic [BITS_BEATS_TOTAL-1:0] idx;
  logic [BITS_BEATS_TOTAL-1:0] beats_last;
  logic sel_last, mtb_last, clr_last;

  assign beats_last = BITS_BEATS_TOTAL'(
    calc_beats_total(int'(kw2), MEMBERS) - 1);

  assign sel_last = (sel == BITS_W_SEL'(SEL_N - 1));
  // colour c spans 2c+1 kernel taps
  assign mtb_last = (mtb == BITS_KH'({clr_i, 1'b0}));
  assign clr_last = (clr_i == BITS_CLR_I'(kw2));
  assign full     = (idx == beats_last);
  assign addr     = BITS_W_ADDR'(idx);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      idx   <= '0;
      sel   <= '0;
      mtb   <= '0;
      clr_i <= '0;
    end else if (en) begin
      idx <= full ? '0 : idx + 1'b1;
      sel <= sel_last ? '0 : sel + 1'b1;
      if (sel_last) begin
        mtb <= mtb_last ? '0 : mtb + 1'b1;
      end
      if (sel_last && mtb_last) begin
        clr_i <= clr_last ? '0 : clr_i + 1'b1;
      end
    end
  end

endmodule

// File: rtl/lrelu_cfg_loader.sv
// Streams config beats into the external config RAM,
// checking framing against the expected beat count.
module lrelu_cfg_loader
  import lrelu_cfg_loader_pkg::*;
#(
  parameter int MEMBERS    = 12,
  parameter int KH_MAX     = 3,
  parameter int KW_MAX     = 3,
  parameter int WORD_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          start,
  input  logic [BITS_KH2-1:0]           kh2,
  input  logic [BITS_KW2-1:0]           kw2,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [MEMBERS*WORD_WIDTH-1:0] s_data,
  input  logic                          s_last,
  output logic                          wr_en,
  output logic [BITS_W_SEL-1:0]         wr_sel,
  output logic [BITS_CLR_I-1:0]         wr_clr_i,
  output logic [BITS_KH-1:0]            wr_mtb,
  output logic [BITS_W_ADDR-1:0]        wr_addr,
  output logic [MEMBERS*WORD_WIDTH-1:0] wr_data,
  output logic                          busy,
  output logic                          done,
  output logic                          err
);

  localparam int KH2_LIM = (KH_MAX - 1) / 2;
  localparam int KW2_LIM = (KW_MAX - 1) / 2;

  lrelu_state_t state, state_nx;

  logic accept, begin_load, frame_err;
  logic cnt_clr, cnt_rstn;
  logic [BITS_KW2-1:0] kw2_q;
  logic [BITS_KH2-1:0] kh2_q;
  logic unused_kh2;

  logic [BITS_W_SEL-1:0]  c_sel;
  logic [BITS_KH-1:0]     c_mtb;
  logic [BITS_CLR_I-1:0]  c_clr_i;
  logic [BITS_W_ADDR-1:0] c_addr;
  logic                   c_full;

  assign accept     = s_valid & (state == LOAD);
  assign cnt_rstn   = rstn & ~cnt_clr;
  assign unused_kh2 = ^kh2_q;

  lrelu_beats_counter #(
    .MEMBERS (MEMBERS)
  ) u_cnt (
    .clk   (clk),
    .rstn  (cnt_rstn),
    .en    (accept),
    .kw2   (kw2_q),
    .sel   (c_sel),
    .mtb   (c_mtb),
    .clr_i (c_clr_i),
    .addr  (c_addr),
    .full  (c_full)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    s_ready    = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    begin_load = 1'b0;
    frame_err  = 1'b0;
    unique case (state)
      LOAD: begin
        s_ready = 1'b1;
        busy    = 1'b1;
        if (s_valid) begin
          if (c_full && s_last) begin
            state_nx = DONE;
          end else if (c_full || s_last) begin
            frame_err = 1'b1;
            state_nx  = IDLE;
          end
        end
      end
      IDLE, DONE: begin
        done = (state == DONE);
        if (start) begin
          begin_load = 1'b1;
          state_nx   = LOAD;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // oversized kernel configs saturate to what the datapath holds
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_clr <= 1'b1;
      kw2_q   <= '0;
      kh2_q   <= '0;
      err     <= 1'b0;
    end else begin
      cnt_clr <= (state_nx != LOAD);
      if (begin_load) begin
        kw2_q <= BITS_KW2'(clip(int'(kw2), KW2_LIM));
        kh2_q <= BITS_KH2'(clip(int'(kh2), KH2_LIM));
        err   <= 1'b0;
      end else if (frame_err) begin
        err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_en    <= 1'b0;
      wr_sel   <= '0;
      wr_clr_i <= '0;
      wr_mtb   <= '0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      wr_en <= accept;
      if (accept) begin
        wr_sel   <= c_sel;
        wr_clr_i <= c_clr_i;
        wr_mtb   <= c_mtb;
        wr_addr  <= c_addr;
        wr_data  <= s_data;
      end
    end
  end

endmodule

// File: doc/lrelu_cfg_loader.md
LRELU_CFG_LOADER -- requirements
Module: lrelu_cfg_loader

Interface
REQ-001 Parameters SHALL be: MEMBERS, default 12, lanes per beat; KH_MAX, default 3, max kernel height; KW_MAX, default 3, max kernel width; WORD_WIDTH, default 8, bits per lane.
REQ-002 Derived widths SHALL come from the shared package: BITS_KH2, BITS_KW2, BITS_KH, BITS_CLR_I, BITS_W_SEL (2), BITS_W_ADDR, BITS_BEATS_TOTAL.
REQ-003 clk  in  1  single clock; all logic on its rising edge.
REQ-004 rstn  in  1  reset, asynchronous assert, active-low.
REQ-005 start  in  1  one-cycle pulse that latches kh2/kw2 and begins a load.
REQ-006 kh2  in  BITS_KH2  (KH-1)/2 for the coming load; kw2  in  BITS_KW2  (KW-1)/2.
REQ-007 s_valid  in  1; s_ready  out  1; s_data  in  MEMBERS*WORD_WIDTH; s_last  in  1: config-beat stream slave.
REQ-008 wr_en  out  1  config-RAM write strobe.
REQ-009 wr_sel  out  BITS_W_SEL; wr_clr_i  out  BITS_CLR_I; wr_mtb  out  BITS_KH; wr_addr  out  BITS_W_ADDR; wr_data  out  MEMBERS*WORD_WIDTH: write address fields and payload.
REQ-010 busy  out  1  load in progress; done  out  1  load completed cleanly; err  out  1  sticky framing error.

Function
REQ-011 FSM SHALL have states IDLE, LOAD, DONE.
REQ-012 IDLE: s_ready=0; start=1 -> latch kh2/kw2, clear beat index, clear err, go LOAD.
REQ-013 LOAD: s_ready=1, busy=1; a beat is accepted when s_valid & s_ready.
REQ-014 Each accepted beat SHALL advance the sub-module counter by one (en = accept); with no accept the counter SHALL hold.
REQ-015 The write for an accepted beat SHALL appear the next cycle: wr_en=1 and wr_sel/wr_clr_i/wr_mtb/wr_addr/wr_data taken from counter outputs and s_data at the accept edge (latency 1, registered).
REQ-016 wr_en SHALL be 0 in every cycle not immediately following an accept.
REQ-017 Expected beats N = calc_beats_total(kw2_latched, MEMBERS); the final beat is the accept with beat index N-1 (counter full).
REQ-018 Final beat with s_last=1 -> go DONE, done=1.
REQ-019 Final beat with s_last=0, or any non-final beat with s_last=1 -> err=1, go IDLE; that beat is still written.
REQ-020 DONE: s_ready=0, done held 1 until the next start; start in DONE behaves as in IDLE.
REQ-021 start while in LOAD SHALL be ignored.
REQ-022 After any LOAD exit the counter SHALL be cleared synchronously before the next load.
REQ-023 Beat index width BITS_BEATS_TOTAL SHALL never overflow; no accepts are possible past index N-1.

Reset
REQ-024 rstn=0 SHALL asynchronously force state IDLE, counter clear, s_ready=0, wr_en=0, all wr_* fields 0, busy=0, done=0, err=0.
REQ-025 Reset mid-LOAD SHALL abort with no further wr_en; a fresh start is required.

Structure
REQ-026 The shared package SHALL hold the FSM state enum, calc_beats_total, calc_beats_max, calc_beats_total_max, and the width localparams of REQ-002.
REQ-027 The beat counter SHALL be the existing lrelu_beats_counter sub-module, instantiated once; its rstn is rstn AND NOT the synchronous clear.
REQ-028 The block SHALL contain no memories; the config RAM is external.

Verification
REQ-029 kh2=1, kw2=1, N beats with s_valid held 1, data = beat index, s_last on beat N-1 -> N wr_en pulses, wr_data 0..N-1 in order, each one cycle after its accept; done=1; err=0.
REQ-030 Same as REQ-029 with s_valid toggling 1,0,1,0 -> wr_* fields identical to REQ-029, wr_en only after accepts, counter holds on gaps.
REQ-031 kw2=0 load then kw2=1 load back-to-back (start in DONE) -> beat counts N0 then N1 match the package, counter restarts at 0.
REQ-032 s_last on beat 2 of N -> 3 writes, err=1, state IDLE, s_ready=0; next start clears err.
REQ-033 rstn pulsed low after 5 beats -> all outputs 0 within the reset cycle, no wr_en afterwards until start.
REQ-034 start pulsed during LOAD -> ignored; beat sequence and write addresses unchanged.
